// File: rtl/ssp_uart_pkg.sv
// rtl/ssp_uart_pkg.sv - shared types and helpers for the UART receive FIFO
package ssp_uart_pkg;

    typedef enum logic [1:0] {
        TO_IDLE,
        TO_COUNT,
        TO_EXPIRED
    } to_state_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ssp_uart_rx_fifo_if.sv
// rtl/ssp_uart_rx_fifo_if.sv - receive FIFO control/status bundle
interface ssp_uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TO_W   = 4,
    parameter int CNT_W  = ssp_uart_pkg::cnt_w(DEPTH)
);
    logic              RFC;
    logic              WE;
    logic [DATA_W-1:0] DI;
    logic              RE;
    logic [DATA_W-1:0] DO;
    logic [CNT_W-1:0]  RFThr;
    logic [TO_W-1:0]   TO_Lim;
    logic              CharTick;
    logic              IE;
    logic [CNT_W-1:0]  rcnt;
    logic              EF;
    logic              R_FF;
    logic              iRHF;
    logic              iRTO;
    logic              OVR;
    logic              IRQ;

    modport master (
        output RFC, WE, DI, RE, RFThr, TO_Lim, CharTick, IE,
        input  DO, rcnt, EF, R_FF, iRHF, iRTO, OVR, IRQ
    );

    modport slave (
        input  RFC, WE, DI, RE, RFThr, TO_Lim, CharTick, IE,
        output DO, rcnt, EF, R_FF, iRHF, iRTO, OVR, IRQ
    );
endinterface

// File: rtl/ssp_uart_fifo_ram.sv
// rtl/ssp_uart_fifo_ram.sv - FIFO storage, sync write, async read, no reset
module ssp_uart_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ssp_uart_rx_fifo.sv
// rtl/ssp_uart_rx_fifo.sv - FWFT receive FIFO with threshold, timeout, overrun and IRQ
module ssp_uart_rx_fifo
    import ssp_uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TO_W   = 4
) (
    input  logic Clk,
    input  logic Rst,
    ssp_uart_rx_fifo_if.slave bus
);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_rcnt;
    logic [CNT_W-1:0]  w_rcnt_nxt;
    logic              r_ef;
    logic              r_ff;
    logic              r_rhf;
    logic              r_rto;
    logic              r_ovr;
    logic              r_irq;
    logic [TO_W-1:0]   r_to_cnt;
    to_state_t         r_to_state;
    logic              w_wr;
    logic              w_rd;
    logic              w_ef_nxt;
    logic [DATA_W-1:0] w_do;

    // When full, a simultaneous pop frees the slot so the write is still accepted.
    assign w_rd = bus.RE & ~r_ef;
    assign w_wr = bus.WE & (~r_ff | bus.RE);

    always_comb begin
        w_rcnt_nxt = r_rcnt;
        if (w_wr && !w_rd) begin
            w_rcnt_nxt = r_rcnt + CNT_W'(1);
        end else if (w_rd && !w_wr) begin
            w_rcnt_nxt = r_rcnt - CNT_W'(1);
        end
    end

    assign w_ef_nxt = (w_rcnt_nxt == '0);

    ssp_uart_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .i_clk   (Clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.DI),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_do)
    );

    always_ff @(posedge Clk) begin
        if (Rst || bus.RFC) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rcnt   <= '0;
            r_ef     <= 1'b1;
            r_ff     <= 1'b0;
            r_rhf    <= 1'b0;
            r_ovr    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (bus.WE && r_ff && !bus.RE) begin
                r_ovr <= 1'b1;
            end
            r_rcnt <= w_rcnt_nxt;
            r_ef   <= w_ef_nxt;
            r_ff   <= (w_rcnt_nxt == CNT_W'(DEPTH));
            r_rhf  <= (bus.RFThr != '0) && (w_rcnt_nxt >= bus.RFThr);
            r_irq  <= bus.IE & (r_rhf | r_rto | r_ovr);
        end
    end

    // Timeout FSM: counts character times only while data sits unread.
    always_ff @(posedge Clk) begin
        if (Rst || bus.RFC) begin
            r_to_state <= TO_IDLE;
            r_to_cnt   <= bus.TO_Lim;
            r_rto      <= 1'b0;
        end else begin
            case (r_to_state)
                TO_IDLE: begin
                    r_to_cnt <= bus.TO_Lim;
                    if (!w_ef_nxt) begin
                        r_to_state <= TO_COUNT;
                    end
                end
                TO_COUNT: begin
                    if (w_ef_nxt) begin
                        r_to_cnt   <= bus.TO_Lim;
                        r_to_state <= TO_IDLE;
                    end else if (bus.WE || bus.RE) begin
                        r_to_cnt <= bus.TO_Lim;
                    end else if (bus.CharTick && r_to_cnt != '0) begin
                        r_to_cnt <= r_to_cnt - TO_W'(1);
                        if (r_to_cnt == TO_W'(1)) begin
                            r_rto      <= 1'b1;
                            r_to_state <= TO_EXPIRED;
                        end
                    end
                end
                TO_EXPIRED: begin
                    if (bus.WE || bus.RE) begin
                        r_to_cnt <= bus.TO_Lim;
                    end
                    if (w_rd) begin
                        r_rto      <= 1'b0;
                        r_to_state <= w_ef_nxt ? TO_IDLE : TO_COUNT;
                    end
                end
                default: begin
                    r_to_state <= TO_IDLE;
                end
            endcase
        end
    end

    assign bus.DO   = w_do;
    assign bus.rcnt = r_rcnt;
    assign bus.EF   = r_ef;
    assign bus.R_FF = r_ff;
    assign bus.iRHF = r_rhf;
    assign bus.iRTO = r_rto;
    assign bus.OVR  = r_ovr;
    assign bus.IRQ  = r_irq;
endmodule

// File: tb/tb_ssp_uart_rx_fifo.sv
// tb/tb_ssp_uart_rx_fifo.sv - directed vector bench for ssp_uart_rx_fifo
module tb_ssp_uart_rx_fifo;
    typedef struct {
        logic       rfc;
        logic       we;
        logic       re;
        logic       tick;
        logic [7:0] di;
        logic       chk_do;
        logic [7:0] e_do;
        logic [4:0] e_rcnt;
        logic       e_ef;
        logic       e_ff;
        logic       e_rhf;
        logic       e_rto;
        logic       e_ovr;
        logic       e_irq;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    ssp_uart_rx_fifo_if #(.DATA_W(8), .DEPTH(16), .TO_W(4)) bus ();

    ssp_uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .TO_W(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    function automatic vec_t mk(input logic rfc, we, re, tick, input logic [7:0] di,
                                input logic chk_do, input logic [7:0] e_do,
                                input logic [4:0] e_rcnt,
                                input logic e_ef, e_ff, e_rhf, e_rto, e_ovr, e_irq);
        vec_t v;
        v.rfc = rfc; v.we = we; v.re = re; v.tick = tick; v.di = di;
        v.chk_do = chk_do; v.e_do = e_do; v.e_rcnt = e_rcnt;
        v.e_ef = e_ef; v.e_ff = e_ff; v.e_rhf = e_rhf;
        v.e_rto = e_rto; v.e_ovr = e_ovr; v.e_irq = e_irq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        bus.RFC = 1'b0;
        bus.WE = 1'b0;
        bus.RE = 1'b0;
        bus.CharTick = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [4:0] rc, input logic ef, ff, rhf,
                           rto, ovr, irq);
        chk({tag, " rcnt"}, 32'(bus.rcnt), 32'(rc));
        chk({tag, " EF"}, 32'(bus.EF), 32'(ef));
        chk({tag, " R_FF"}, 32'(bus.R_FF), 32'(ff));
        chk({tag, " iRHF"}, 32'(bus.iRHF), 32'(rhf));
        chk({tag, " iRTO"}, 32'(bus.iRTO), 32'(rto));
        chk({tag, " OVR"}, 32'(bus.OVR), 32'(ovr));
        chk({tag, " IRQ"}, 32'(bus.IRQ), 32'(irq));
    endtask

    vec_t       tbl [19];
    logic [7:0] q [$];

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 8'h41, 1, 8'h41, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 8'h42, 1, 8'h41, 2, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 8'h00, 1, 8'h42, 1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 8'h10, 1, 8'h10, 1, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 0, 8'h11, 1, 8'h10, 2, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 8'h12, 1, 8'h10, 3, 0, 0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 8'h00, 1, 8'h10, 3, 0, 0, 1, 0, 0, 1);
        tbl[10] = mk(0, 1, 1, 0, 8'h13, 1, 8'h11, 3, 0, 0, 1, 0, 0, 1);
        tbl[11] = mk(0, 0, 1, 0, 8'h00, 1, 8'h12, 2, 0, 0, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 8'h00, 1, 8'h12, 2, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 1, 8'h00, 1, 8'h12, 2, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 1, 8'h00, 1, 8'h12, 2, 0, 0, 0, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 8'h00, 1, 8'h12, 2, 0, 0, 0, 1, 0, 1);
        tbl[16] = mk(0, 0, 1, 0, 8'h00, 1, 8'h13, 1, 0, 0, 0, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 8'h00, 1, 8'h13, 1, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);

        bus.RFC = 1'b0; bus.WE = 1'b0; bus.DI = '0; bus.RE = 1'b0; bus.CharTick = 1'b0;
        bus.RFThr = 5'd3; bus.TO_Lim = 4'd2; bus.IE = 1'b1;
        Rst = 1'b1;
        cyc();

        for (int i = 0; i < 19; i++) begin
            bus.RFC = tbl[i].rfc; bus.WE = tbl[i].we; bus.RE = tbl[i].re;
            bus.CharTick = tbl[i].tick; bus.DI = tbl[i].di;
            cyc();
            chk_all($sformatf("vec%0d", i), tbl[i].e_rcnt, tbl[i].e_ef, tbl[i].e_ff,
                    tbl[i].e_rhf, tbl[i].e_rto, tbl[i].e_ovr, tbl[i].e_irq);
            if (tbl[i].chk_do) chk($sformatf("vec%0d DO", i), 32'(bus.DO), 32'(tbl[i].e_do));
        end

        // Threshold at 8
        bus.RFThr = 5'd8; bus.IE = 1'b0; bus.TO_Lim = 4'd0;
        Rst = 1'b1; cyc();
        for (int k = 0; k < 8; k++) begin
            bus.WE = 1'b1; bus.DI = 8'(k); cyc();
            if (k == 6) chk("thr7 iRHF", 32'(bus.iRHF), 32'd0);
        end
        chk("thr8 iRHF", 32'(bus.iRHF), 32'd1);
        bus.RE = 1'b1; cyc();
        chk("thr pop iRHF", 32'(bus.iRHF), 32'd0);

        // Full FIFO, simultaneous write and read, then overrun and clear
        bus.RFThr = 5'd0; bus.IE = 1'b1;
        Rst = 1'b1; cyc();
        q.delete();
        for (int k = 0; k < 16; k++) begin
            bus.WE = 1'b1; bus.DI = 8'(k); q.push_back(8'(k)); cyc();
        end
        chk_all("full", 5'd16, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            bus.WE = 1'b1; bus.RE = 1'b1; bus.DI = 8'(8'h40 + k);
            void'(q.pop_front()); q.push_back(8'(8'h40 + k));
            cyc();
            chk($sformatf("wr_rd%0d rcnt", k), 32'(bus.rcnt), 32'd16);
            chk($sformatf("wr_rd%0d OVR", k), 32'(bus.OVR), 32'd0);
            chk($sformatf("wr_rd%0d DO", k), 32'(bus.DO), 32'(q[0]));
        end
        bus.WE = 1'b1; bus.DI = 8'hEE; cyc();
        chk_all("ovr", 5'd16, 0, 1, 0, 0, 1, 0);
        cyc();
        chk("ovr IRQ", 32'(bus.IRQ), 32'd1);
        chk("ovr DO kept", 32'(bus.DO), 32'(q[0]));
        bus.RFC = 1'b1; cyc();
        chk_all("rfc", 5'd0, 1, 0, 0, 0, 0, 0);

        // Timeout of 4 character times, then disabled timeout
        bus.IE = 1'b0; bus.TO_Lim = 4'd4;
        Rst = 1'b1; cyc();
        bus.WE = 1'b1; bus.DI = 8'h55; cyc();
        for (int k = 1; k <= 4; k++) begin
            bus.CharTick = 1'b1; cyc();
            chk($sformatf("to tick%0d iRTO", k), 32'(bus.iRTO), (k == 4) ? 32'd1 : 32'd0);
        end
        bus.RE = 1'b1; cyc();
        chk("to pop iRTO", 32'(bus.iRTO), 32'd0);
        chk("to pop EF", 32'(bus.EF), 32'd1);
        bus.TO_Lim = 4'd0;
        bus.WE = 1'b1; bus.DI = 8'h56; cyc();
        for (int k = 0; k < 6; k++) begin
            bus.CharTick = 1'b1; cyc();
        end
        chk("to0 iRTO", 32'(bus.iRTO), 32'd0);

        // Reset in the middle of a burst with a pending timeout
        bus.TO_Lim = 4'd1; bus.RFThr = 5'd4; bus.IE = 1'b1;
        Rst = 1'b1; cyc();
        for (int k = 0; k < 5; k++) begin
            bus.WE = 1'b1; bus.DI = 8'(8'h60 + k); cyc();
        end
        bus.CharTick = 1'b1; cyc();
        chk_all("pre_rst", 5'd5, 0, 0, 1, 1, 0, 1);
        Rst = 1'b1; bus.WE = 1'b1; bus.DI = 8'h77; cyc();
        chk_all("mid_rst", 5'd0, 1, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
